// File: rtl/vga_plot_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : vga_plot_arbiter_if
// Description : Engine-side request/plot bundle and arbitrated VGA plot port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vga_plot_arbiter_if #(
    parameter int N = 3
);
    logic [N-1:0]   req;
    logic [9*N-1:0] x_in;
    logic [9*N-1:0] y_in;
    logic [6*N-1:0] colour_in;
    logic [N-1:0]   wen_in;
    logic [N-1:0]   grant;
    logic [8:0]     x;
    logic [8:0]     y;
    logic [5:0]     colour;
    logic           writeEn;
    logic           busy;
    logic           timeout;

    modport master (
        output req, x_in, y_in, colour_in, wen_in,
        input  grant, x, y, colour, writeEn, busy, timeout
    );

    modport slave (
        input  req, x_in, y_in, colour_in, wen_in,
        output grant, x, y, colour, writeEn, busy, timeout
    );
endinterface

`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
//------------------------------------------------------------------------------
// Module      : vga_plot_arbiter
// Description : Round-robin owner of the VGA plot port with hold watchdog.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_plot_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 1000000,
    parameter int HOLD_W   = 20
) (
    input  wire              clk,
    input  wire              reset,
    vga_plot_arbiter_if.slave bus
);

    localparam int c_idx_w = $clog2(N);
    localparam int c_slots = 1 << c_idx_w;
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    logic [N-1:0]        r_grant;
    logic [c_idx_w-1:0]  r_g;
    logic [c_idx_w-1:0]  r_last;
    logic [HOLD_W-1:0]   r_hold;
    logic [8:0]          r_x;
    logic [8:0]          r_y;
    logic [5:0]          r_colour;
    logic                r_wen;
    logic                r_busy;
    logic                r_timeout;

    logic [8:0]          w_x_arr      [c_slots];
    logic [8:0]          w_y_arr      [c_slots];
    logic [5:0]          w_colour_arr [c_slots];
    logic [c_slots-1:0]  w_req_v;
    logic [c_slots-1:0]  w_wen_v;
    logic [c_idx_w-1:0]  w_sel;
    logic                w_any;
    logic [N-1:0]        w_onehot;

    // Pad to a power of two so indexing by r_g never leaves the array.
    generate
        for (genvar i = 0; i < c_slots; i++) begin : g_slot
            if (i < N) begin : g_engine
                assign w_x_arr[i]      = bus.x_in[9*i +: 9];
                assign w_y_arr[i]      = bus.y_in[9*i +: 9];
                assign w_colour_arr[i] = bus.colour_in[6*i +: 6];
                assign w_req_v[i]      = bus.req[i];
                assign w_wen_v[i]      = bus.wen_in[i];
            end else begin : g_pad
                assign w_x_arr[i]      = '0;
                assign w_y_arr[i]      = '0;
                assign w_colour_arr[i] = '0;
                assign w_req_v[i]      = 1'b0;
                assign w_wen_v[i]      = 1'b0;
            end
        end
    endgenerate

    // Scan downward so the requester nearest after r_last wins.
    always_comb begin
        int idx;
        idx   = 0;
        w_sel = '0;
        w_any = |bus.req;
        for (int k = N; k >= 1; k--) begin
            idx = int'(r_last) + k;
            if (idx >= N) idx = idx - N;
            if (w_req_v[idx]) w_sel = c_idx_w'(idx);
        end
        w_onehot = {{(N-1){1'b0}}, 1'b1} << w_sel;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_g       <= '0;
            r_last    <= c_idx_w'(N - 1);
            r_hold    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_wen     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_onehot;
                        r_g     <= w_sel;
                        r_busy  <= 1'b1;
                        r_hold  <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_x      <= w_x_arr[r_g];
                    r_y      <= w_y_arr[r_g];
                    r_colour <= w_colour_arr[r_g];
                    r_wen    <= w_wen_v[r_g];
                    r_hold   <= r_hold + 1'b1;
                    // A voluntary drop takes precedence over an expiring watchdog.
                    if (!w_req_v[r_g]) begin
                        r_state <= S_RELEASE;
                    end else if (r_hold == c_hold_last) begin
                        r_state   <= S_RELEASE;
                        r_timeout <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_grant <= '0;
                    r_wen   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_last  <= r_g;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant   = r_grant;
    assign bus.x       = r_x;
    assign bus.y       = r_y;
    assign bus.colour  = r_colour;
    assign bus.writeEn = r_wen;
    assign bus.busy    = r_busy;
    assign bus.timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_vga_plot_arbiter
// Description : Directed vector bench for vga_plot_arbiter (N=3, MAX_HOLD=16).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_plot_arbiter;

    localparam logic [8:0] X0 = 9'd10;  localparam logic [8:0] Y0 = 9'd44; localparam logic [5:0] C0 = 6'b001001;
    localparam logic [8:0] X1 = 9'd20;  localparam logic [8:0] Y1 = 9'd55; localparam logic [5:0] C1 = 6'b010010;
    localparam logic [8:0] X2 = 9'd300; localparam logic [8:0] Y2 = 9'd66; localparam logic [5:0] C2 = 6'b100100;

    typedef struct packed {
        logic [2:0] req;
        logic [2:0] wen;
        logic [2:0] grant;
        logic       we;
        logic [8:0] x;
        logic [8:0] y;
        logic [5:0] c;
        logic       busy;
        logic       to;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs [19];

    always #5 clk = ~clk;

    vga_plot_arbiter_if #(.N(3)) bus ();

    vga_plot_arbiter #(
        .N        (3),
        .MAX_HOLD (16),
        .HOLD_W   (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [29:0] snap();
        return {bus.grant, bus.writeEn, bus.x, bus.y, bus.colour, bus.busy, bus.timeout};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Grant stays one-hot (or empty) and engine 2's x never leaks while engine 1 owns the port.
    always @(negedge clk) begin
        if (!reset) begin
            check("onehot0", 64'($onehot0(bus.grant)), 64'd1);
            check("foreign_x", 64'(bus.grant == 3'b010 && bus.x == X2), 64'd0);
        end
    end

    initial begin
        //            req     wen     grant   we    x   y   c   busy  to
        vecs[0]  = '{3'b001, 3'b001, 3'b001, 1'b0, 9'd0, 9'd0, 6'd0, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 3'b001, 3'b001, 1'b1, X0, Y0, C0, 1'b1, 1'b0};
        vecs[2]  = '{3'b111, 3'b001, 3'b001, 1'b1, X0, Y0, C0, 1'b1, 1'b0};
        vecs[3]  = '{3'b110, 3'b001, 3'b001, 1'b1, X0, Y0, C0, 1'b1, 1'b0};
        vecs[4]  = '{3'b110, 3'b010, 3'b000, 1'b0, X0, Y0, C0, 1'b0, 1'b0};
        vecs[5]  = '{3'b110, 3'b110, 3'b010, 1'b0, X0, Y0, C0, 1'b1, 1'b0};
        vecs[6]  = '{3'b110, 3'b110, 3'b010, 1'b1, X1, Y1, C1, 1'b1, 1'b0};
        vecs[7]  = '{3'b110, 3'b100, 3'b010, 1'b0, X1, Y1, C1, 1'b1, 1'b0};
        vecs[8]  = '{3'b111, 3'b110, 3'b010, 1'b1, X1, Y1, C1, 1'b1, 1'b0};
        vecs[9]  = '{3'b101, 3'b100, 3'b010, 1'b0, X1, Y1, C1, 1'b1, 1'b0};
        vecs[10] = '{3'b101, 3'b100, 3'b000, 1'b0, X1, Y1, C1, 1'b0, 1'b0};
        vecs[11] = '{3'b101, 3'b100, 3'b100, 1'b0, X1, Y1, C1, 1'b1, 1'b0};
        vecs[12] = '{3'b101, 3'b100, 3'b100, 1'b1, X2, Y2, C2, 1'b1, 1'b0};
        vecs[13] = '{3'b001, 3'b100, 3'b100, 1'b1, X2, Y2, C2, 1'b1, 1'b0};
        vecs[14] = '{3'b001, 3'b001, 3'b000, 1'b0, X2, Y2, C2, 1'b0, 1'b0};
        vecs[15] = '{3'b001, 3'b001, 3'b001, 1'b0, X2, Y2, C2, 1'b1, 1'b0};
        vecs[16] = '{3'b000, 3'b001, 3'b001, 1'b1, X0, Y0, C0, 1'b1, 1'b0};
        vecs[17] = '{3'b000, 3'b000, 3'b000, 1'b0, X0, Y0, C0, 1'b0, 1'b0};
        vecs[18] = '{3'b000, 3'b000, 3'b000, 1'b0, X0, Y0, C0, 1'b0, 1'b0};

        bus.req       = 3'b000;
        bus.wen_in    = 3'b000;
        bus.x_in      = {X2, X1, X0};
        bus.y_in      = {Y2, Y1, Y0};
        bus.colour_in = {C2, C1, C0};

        #1 reset = 1'b1;
        #2 check("reset_state", 64'(snap()), 64'd0);
        step();
        reset = 1'b0;

        // Round robin 0,1,2,0 with final-write forwarding and foreign wen ignored.
        for (int i = 0; i < 19; i++) begin
            bus.req    = vecs[i].req;
            bus.wen_in = vecs[i].wen;
            step();
            check($sformatf("vec%0d", i), 64'(snap()),
                  64'({vecs[i].grant, vecs[i].we, vecs[i].x, vecs[i].y,
                       vecs[i].c, vecs[i].busy, vecs[i].to}));
        end

        // Asynchronous reset in the middle of a grant.
        bus.req    = 3'b001;
        bus.wen_in = 3'b001;
        step();
        step();
        check("pre_reset", 64'({bus.grant, bus.writeEn}), 64'({3'b001, 1'b1}));
        #2 reset = 1'b1;
        #1 check("async_reset", 64'(snap()), 64'd0);
        bus.req    = 3'b111;
        bus.wen_in = 3'b000;
        reset      = 1'b0;
        step();
        check("req111_after_reset", 64'({bus.grant, bus.busy}), 64'({3'b001, 1'b1}));

        // Watchdog: engine 0 keeps requesting while engine 1 waits.
        bus.req = 3'b011;
        for (int c = 1; c <= 15; c++) begin
            step();
            check($sformatf("hold%0d", c), 64'({bus.grant, bus.timeout}), 64'({3'b001, 1'b0}));
        end
        step();
        check("timeout_pulse", 64'({bus.grant, bus.timeout, bus.busy}), 64'({3'b001, 1'b1, 1'b1}));
        step();
        check("timeout_release", 64'({bus.grant, bus.timeout, bus.busy}), 64'({3'b000, 1'b0, 1'b0}));
        step();
        check("after_timeout", 64'(bus.grant), 64'(3'b010));
        step();
        step();
        check("e1_holds", 64'(bus.grant), 64'(3'b010));
        bus.req = 3'b001;
        step();
        step();
        check("e1_release", 64'(bus.grant), 64'(3'b000));
        step();
        check("e0_regrant", 64'(bus.grant), 64'(3'b001));

        // Dropping request on the expiring cycle is a normal release.
        for (int c = 1; c <= 15; c++) begin
            step();
            check($sformatf("hold_b%0d", c), 64'({bus.grant, bus.timeout}), 64'({3'b001, 1'b0}));
        end
        bus.req = 3'b000;
        step();
        check("drop16", 64'({bus.grant, bus.timeout}), 64'({3'b001, 1'b0}));
        step();
        check("drop16_release", 64'({bus.grant, bus.timeout, bus.busy}), 64'({3'b000, 1'b0, 1'b0}));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_plot_arbiter.md
Name: vga_plot_arbiter

Overview:
- Shares the single VGA plot port (x, y, colour, writeEn) between N drawing engines, e.g. score bar, word sequence drawer and screen clear.
- Uses a request/grant handshake with round-robin fairness. One engine owns the port until it drops its request.
- A watchdog forcibly releases an engine that holds the port beyond MAX_HOLD cycles.
- Sits between the drawing engines and the VGA adapter.

Parameters:
- N, 3: number of requesting engines (2..8).
- MAX_HOLD, 1000000: maximum consecutive GRANT cycles before forced release.
- HOLD_W, 20: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-engine request, level. Bit i belongs to engine i.
- x_in  in  9*N  engine x coordinates. Engine i uses bits [9i+8:9i].
- y_in  in  9*N  engine y coordinates, packed the same way as x_in.
- colour_in  in  6*N  engine colours. Engine i uses bits [6i+5:6i].
- wen_in  in  N  per-engine plot write enable.
- grant  out  N  one-hot grant, registered.
- x  out  9  plot x to the VGA adapter, registered.
- y  out  9  plot y, registered.
- colour  out  6  plot colour, registered.
- writeEn  out  1  plot write strobe, registered.
- busy  out  1  high while any engine holds the grant.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (asynchronous, immediate) forces: state IDLE; grant=0; x=0; y=0; colour=0; writeEn=0; busy=0; timeout=0; hold counter=0; last pointer=N-1, so engine 0 has first priority.
- Reset asserted mid-grant drops grant and writeEn at once. No partial state survives reset.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req is nonzero at a clock edge, select the first set bit searching upward from last+1, modulo N.
  - At that edge: load grant with the one-hot of the selection, record g, set busy=1, clear the hold counter, go to GRANT.
  - Latency: req rises before edge k, grant is high after edge k.
  - If req is zero, stay in IDLE.
- GRANT, on each edge:
  - x/y/colour/writeEn are loaded from engine g's slice of x_in/y_in/colour_in/wen_in. The plot path has 1 cycle of latency.
  - wen_in from non-granted engines is ignored entirely.
  - The hold counter increments.
  - If req[g]=0, go to RELEASE. The write presented in that final cycle is still forwarded.
  - Else if the hold counter equals MAX_HOLD-1, go to RELEASE and pulse timeout for one cycle after the edge.
  - If req[g] drops in the same cycle the counter expires, this is a normal release and timeout stays 0.
- RELEASE, for one cycle:
  - grant=0, writeEn=0, busy=0. x/y/colour hold their values.
  - last := g.
  - Next state is IDLE. This gives one guaranteed idle cycle between owners, so the VGA adapter never sees back-to-back writes from two engines.
- A forcibly released engine that keeps req high is treated as a new request. Round-robin puts it behind every other pending engine.
- Requests that change while another engine holds the grant have no effect until IDLE.
- Engines must finish their writes before dropping req. The arbiter never truncates a grant except on timeout or reset.
- Minimum handoff: the last owner's final write to the next owner's first forwarded write takes 3 edges (RELEASE, IDLE arbitration, first GRANT sample).
- Outputs are glitch-free. Every output is a flop, with no combinational path from req or wen_in to any output.

Test Plan:
- Reset, then req=001 and hold it; drive engine 0 with x=10, y=44, colour=6'b001001, wen=1. Required: grant=001 one edge later; x=10, y=44, colour=001001, writeEn=1 one edge after grant; busy=1.
- Drop req[0] while req[2:1]=11. Required: grant 001 -> RELEASE (grant=000, writeEn=0) -> IDLE -> grant=010. Then drop req[1]: grant=100. Then drop req[2] with req[0]=1: grant=001, confirming round-robin order 0,1,2,0.
- Engine 1 granted and engine 2 asserts wen_in=1 with x=300. Required: x never shows 300 and writeEn tracks only wen_in[1].
- Set MAX_HOLD=16 and hold req[0] high forever with req[1]=1. Required: after 16 GRANT cycles, a one-cycle timeout pulse and RELEASE; engine 1 is granted next and engine 0 only after engine 1 releases. Repeat with req[0] dropping on cycle 16: no timeout pulse.
- Assert reset mid-GRANT with writeEn=1. Required: grant=000, writeEn=0, x=y=colour=0 immediately, without waiting for a clock edge. After release, engine 0 wins when req=111.
- Simultaneous req=111 from IDLE after reset. Required: grant=001 first, and grant is exactly one-hot in every cycle throughout the sequence.
